// File: rtl/cpu_fetch_decode_pkg.sv
// Shared definitions for the fetch/decode stage of the 8-bit processor:
// opcodes, ALU function codes, instruction field positions and FSM states.
package cpu_defs;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam int OP_LSB   = 24;
    localparam int DEST_LSB = 16;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_LSB = 0;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_e;

endpackage

// File: rtl/cpu_fetch_decode_pc_next.sv
// Next fetch address: PC+4, optionally plus a sign-extended word offset.
// All arithmetic wraps silently modulo 2^PC_WIDTH.
module pc_next #(
    parameter int PC_WIDTH = 32
) (
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic [7:0]          offset_i,
    input  logic                take_i,
    output logic [PC_WIDTH-1:0] pc_next_o
);

    logic [PC_WIDTH-1:0] seq_pc;
    logic [PC_WIDTH-1:0] byte_off;

    assign seq_pc   = pc_i + PC_WIDTH'(4);
    assign byte_off = {{(PC_WIDTH-10){offset_i[7]}}, offset_i, 2'b00};
    assign pc_next_o = take_i ? seq_pc + byte_off : seq_pc;

endmodule

// File: rtl/cpu_fetch_decode.sv
// Fetch/decode control stage: PC, RUN/HALT FSM, retired counter and
// combinational decode of the current instruction word.
module cpu_fetch_decode
    import cpu_defs::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [31:0]          INSTRUCTION,
    input  logic                 IMEM_BUSY,
    input  logic                 ZERO,
    output logic [PC_WIDTH-1:0]  PC,
    output logic [2:0]           WRITEREG,
    output logic [2:0]           READREG1,
    output logic [2:0]           READREG2,
    output logic                 WRITEENABLE,
    output logic [7:0]           IMMEDIATE,
    output logic [2:0]           ALUOP,
    output logic                 IMM_SEL,
    output logic                 NEG_SEL,
    output logic                 HALTED,
    output logic [CNT_WIDTH-1:0] RETIRED
);

    state_e               state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d, pc_nxt;
    logic [CNT_WIDTH-1:0] ret_q, ret_d;

    logic [7:0] op;
    logic [7:0] dest;
    logic       dec_we;
    logic       legal;
    logic       is_j;
    logic       is_beq;
    logic       unused_bits;

    assign op   = INSTRUCTION[OP_LSB +: 8];
    assign dest = INSTRUCTION[DEST_LSB +: 8];

    assign WRITEREG  = INSTRUCTION[DEST_LSB +: 3];
    assign READREG1  = INSTRUCTION[SRC1_LSB +: 3];
    assign READREG2  = INSTRUCTION[SRC2_LSB +: 3];
    assign IMMEDIATE = INSTRUCTION[SRC2_LSB +: 8];

    assign unused_bits = ^INSTRUCTION[15:11];

    always_comb begin
        ALUOP   = ALU_FWD;
        IMM_SEL = 1'b0;
        NEG_SEL = 1'b0;
        dec_we  = 1'b0;
        legal   = 1'b1;
        is_j    = 1'b0;
        is_beq  = 1'b0;
        unique case (op)
            OP_LOADI: begin
                IMM_SEL = 1'b1;
                dec_we  = 1'b1;
            end
            OP_MOV: dec_we = 1'b1;
            OP_ADD: begin
                ALUOP  = ALU_ADD;
                dec_we = 1'b1;
            end
            OP_SUB: begin
                ALUOP   = ALU_ADD;
                NEG_SEL = 1'b1;
                dec_we  = 1'b1;
            end
            OP_AND: begin
                ALUOP  = ALU_AND;
                dec_we = 1'b1;
            end
            OP_OR: begin
                ALUOP  = ALU_OR;
                dec_we = 1'b1;
            end
            OP_J: is_j = 1'b1;
            OP_BEQ: begin
                ALUOP   = ALU_ADD;
                NEG_SEL = 1'b1;
                is_beq  = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    pc_next #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_next (
        .pc_i      (pc_q),
        .offset_i  (dest),
        .take_i    (is_j | (is_beq & ZERO)),
        .pc_next_o (pc_nxt)
    );

    // Only a fetched instruction in RUN advances anything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ret_d   = ret_q;
        if (state_q == S_RUN && !IMEM_BUSY) begin
            if (!legal) begin
                state_d = S_HALT;
            end else begin
                pc_d  = pc_nxt;
                ret_d = (&ret_q) ? ret_q : ret_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_RUN;
            pc_q    <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ret_q   <= ret_d;
        end
    end

    assign WRITEENABLE = dec_we & (state_q == S_RUN) & ~IMEM_BUSY & ~RESET;
    assign PC          = pc_q;
    assign HALTED      = (state_q == S_HALT);
    assign RETIRED     = ret_q;

endmodule

// File: tb/tb_cpu_fetch_decode.sv
// Scoreboard bench for cpu_fetch_decode: directed plus random stimulus
// checked against an instruction-level reference model.
module tb_cpu_fetch_decode;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] INSTRUCTION;
    logic        IMEM_BUSY;
    logic        ZERO;
    logic [31:0] PC;
    logic [2:0]  WRITEREG, READREG1, READREG2, ALUOP;
    logic        WRITEENABLE, IMM_SEL, NEG_SEL, HALTED;
    logic [7:0]  IMMEDIATE;
    logic [15:0] RETIRED;

    cpu_fetch_decode dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .INSTRUCTION (INSTRUCTION),
        .IMEM_BUSY   (IMEM_BUSY),
        .ZERO        (ZERO),
        .PC          (PC),
        .WRITEREG    (WRITEREG),
        .READREG1    (READREG1),
        .READREG2    (READREG2),
        .WRITEENABLE (WRITEENABLE),
        .IMMEDIATE   (IMMEDIATE),
        .ALUOP       (ALUOP),
        .IMM_SEL     (IMM_SEL),
        .NEG_SEL     (NEG_SEL),
        .HALTED      (HALTED),
        .RETIRED     (RETIRED)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic        halted;
        logic [15:0] retired;
        logic        we;
        logic [2:0]  wr, r1, r2, aluop;
        logic [7:0]  imm;
        logic        immsel, negsel;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    logic [31:0] m_pc = 0;
    logic        m_halt = 0;
    int          m_ret = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("PC", PC, e.pc);
            chk("HALTED", {31'b0, HALTED}, {31'b0, e.halted});
            chk("RETIRED", {16'b0, RETIRED}, {16'b0, e.retired});
            chk("WRITEENABLE", {31'b0, WRITEENABLE}, {31'b0, e.we});
            chk("WRITEREG", {29'b0, WRITEREG}, {29'b0, e.wr});
            chk("READREG1", {29'b0, READREG1}, {29'b0, e.r1});
            chk("READREG2", {29'b0, READREG2}, {29'b0, e.r2});
            chk("IMMEDIATE", {24'b0, IMMEDIATE}, {24'b0, e.imm});
            chk("ALUOP", {29'b0, ALUOP}, {29'b0, e.aluop});
            chk("IMM_SEL", {31'b0, IMM_SEL}, {31'b0, e.immsel});
            chk("NEG_SEL", {31'b0, NEG_SEL}, {31'b0, e.negsel});
        end
    end

    // Apply one cycle of inputs, queue the expected view, then advance the model.
    task automatic step(input logic r, input logic [31:0] ins,
                        input logic b, input logic z);
        exp_t e;
        int   op;
        int   off;
        bit   we, legal, taken;
        @(posedge CLK);
        #1;
        RESET = r;
        INSTRUCTION = ins;
        IMEM_BUSY = b;
        ZERO = z;
        op = int'(ins[31:24]);
        legal = (op <= 7);
        we = (op <= 5);
        e.pc = m_pc;
        e.halted = m_halt;
        e.retired = m_ret[15:0];
        e.we = we && !m_halt && !b && !r;
        e.wr = ins[18:16];
        e.r1 = ins[10:8];
        e.r2 = ins[2:0];
        e.imm = ins[7:0];
        e.immsel = (op == 0);
        e.negsel = (op == 3) || (op == 7);
        e.aluop = (op == 2 || op == 3 || op == 7) ? 3'd1 :
                  (op == 4) ? 3'd2 : (op == 5) ? 3'd3 : 3'd0;
        sbq.push_back(e);
        off = int'($signed(ins[23:16]));
        taken = (op == 6) || (op == 7 && z);
        if (r) begin
            m_pc = 0;
            m_halt = 0;
            m_ret = 0;
        end else if (!m_halt && !b) begin
            if (!legal) begin
                m_halt = 1;
            end else begin
                m_pc = m_pc + 32'd4 + (taken ? 32'(off * 4) : 32'd0);
                if (m_ret < 65535) m_ret = m_ret + 1;
            end
        end
    endtask

    function automatic logic [31:0] rand_ins(input bit allow_stop);
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 99);
        if (allow_stop && k < 2) w[31:24] = 8'hFF;
        else if (allow_stop && k < 4) w[31:24] = 8'(8 + $urandom_range(0, 246));
        else w[31:24] = 8'($urandom_range(0, 7));
        return w;
    endfunction

    initial begin
        RESET = 1'b1;
        INSTRUCTION = 32'h0;
        IMEM_BUSY = 1'b0;
        ZERO = 1'b0;
        @(posedge CLK);

        step(1, 32'h0002005F, 0, 0);
        step(0, 32'h0002005F, 0, 0);
        step(0, 32'h03040102, 0, 0);
        step(0, 32'h01000000, 0, 0);
        step(0, 32'h01000000, 0, 0);
        step(0, 32'h06FE0000, 0, 0);
        step(0, 32'h01000000, 0, 0);
        step(1, 32'h01000000, 0, 0);
        step(0, 32'h06FE0000, 0, 0);
        step(0, 32'h04010203, 0, 1);
        step(0, 32'h07030000, 0, 1);
        step(0, 32'h07030000, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 32'h02010203, 1, 0);
        step(0, 32'h02010203, 0, 0);
        step(0, 32'h2A000000, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 32'h0002005F, 0, 1);
        step(1, 32'h2A000000, 1, 0);
        step(0, 32'h05030201, 0, 0);
        step(0, 32'hFF000000, 1, 0);
        step(1, 32'h01000000, 1, 0);
        step(0, 32'h01000000, 0, 0);

        for (int i = 0; i < 600; i++) begin
            bit r;
            r = m_halt ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 99) < 3);
            step(r, rand_ins(1'b1), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)));
        end

        step(1, 32'h01000000, 0, 0);
        for (int i = 0; i < 65540; i++) begin
            step(0, rand_ins(1'b0) & 32'h03FFFFFF, 0, 0);
        end
        step(0, 32'h0002005F, 1, 0);

        @(posedge CLK);
        @(posedge CLK);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_fetch_decode.md
Name: cpu_fetch_decode

Overview:
- Upstream control stage of the simple 8-bit processor. It holds the program counter (PC) and decodes the current 32-bit instruction word.
- It drives the register file's address and write-enable inputs, plus ALU/mux selects.
- It handles jumps, conditional branches (beq), instruction-memory stalls and a halt state.
- Single-cycle datapath: decode is combinational from INSTRUCTION; PC, FSM and counter update on CLK.

Parameters:
- PC_WIDTH, 32, width of program counter / byte address.
- CNT_WIDTH, 16, width of retired-instruction counter.

Ports:
- CLK  in  1  system clock, all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- INSTRUCTION  in  32  instruction word at PC; valid when IMEM_BUSY=0.
- IMEM_BUSY  in  1  instruction memory not ready; stall.
- ZERO  in  1  ALU zero flag for the current instruction.
- PC  out  PC_WIDTH  current fetch address.
- WRITEREG  out  3  register file write address (INSTRUCTION[18:16]).
- READREG1  out  3  register file read port 1 (INSTRUCTION[10:8]).
- READREG2  out  3  register file read port 2 (INSTRUCTION[2:0]).
- WRITEENABLE  out  1  register file write strobe.
- IMMEDIATE  out  8  INSTRUCTION[7:0].
- ALUOP  out  3  ALU function select.
- IMM_SEL  out  1  1 selects IMMEDIATE as ALU operand 2.
- NEG_SEL  out  1  1 selects two's complement of operand 2.
- HALTED  out  1  processor is in HALT.
- RETIRED  out  CNT_WIDTH  count of retired instructions.

Behaviour:
- Reset and timing
  - One clock; reset is synchronous and active-high.
  - At a rising CLK edge with RESET=1: PC=0, state=RUN, RETIRED=0. RESET has priority over all other inputs.
  - While RESET=1, WRITEENABLE=0 combinationally.
  - No artificial # delays; zero-delay synthesizable RTL.
- Instruction fields
  - OP=[31:24], DEST=[23:16], SRC1=[15:8], SRC2/IMM=[7:0].
  - For j/beq, DEST is a signed 8-bit word offset.
- Opcodes and decode
  - 0x00 loadi: ALUOP=000, IMM_SEL=1, WE=1.
  - 0x01 mov: ALUOP=000, WE=1.
  - 0x02 add: ALUOP=001, WE=1.
  - 0x03 sub: ALUOP=001, NEG_SEL=1, WE=1.
  - 0x04 and: ALUOP=010, WE=1.
  - 0x05 or: ALUOP=011, WE=1.
  - 0x06 j: WE=0.
  - 0x07 beq: ALUOP=001, NEG_SEL=1, WE=0.
  - 0xFF halt: WE=0.
  - Any other opcode is illegal and is handled like halt.
  - Unlisted selects are 0.
- FSM states: RUN, HALT.
  - RUN to HALT: at an edge with IMEM_BUSY=0 and OP=halt or illegal. PC does not advance; RETIRED does not increment.
  - HALT exits only via RESET.
  - HALTED=1 iff state=HALT.
- Gating
  - WRITEENABLE = decoded WE AND state=RUN AND IMEM_BUSY=0 AND RESET=0.
  - The register file samples it on the same rising edge.
- Next PC (state=RUN, IMEM_BUSY=0)
  - Base: PC+4.
  - j: PC+4+(sext(DEST)<<2).
  - beq with ZERO=1 at the edge: same target as j.
  - beq with ZERO=0: PC+4.
  - All arithmetic is modulo 2^PC_WIDTH; wrap at all-ones is silent.
- Stall: IMEM_BUSY=1 holds PC and RETIRED, forces WE=0 and takes no state transition.
- HALT: PC and RETIRED hold.
- RETIRED increments by 1 per instruction completed in RUN (not stall, not halt/illegal). It saturates at all-ones.
- RESET asserted mid-stall or in HALT returns the block to its reset state on the next edge.

Decomposition:
- Package cpu_defs holds:
  - opcode constants (OP_LOADI..OP_BEQ, OP_HALT);
  - ALUOP encodings (ALU_FWD, ALU_ADD, ALU_AND, ALU_OR);
  - field bit-position constants;
  - FSM state typedef.
- One sub-module, pc_next: combinational next-PC calculator (PC+4, sign-extended shifted offset, branch select).
- Decoder stays inline.

Test Plan:
- Reset and loadi: RESET high 1 cycle, then loadi r2,#95 (0x0002005F) → PC=0 after reset; WRITEREG=2, IMM_SEL=1, WE=1; PC=4 and RETIRED=1 next edge.
- Arithmetic decode: sub r4,r1,r2 (0x03040102) → READREG1=1, READREG2=2, ALUOP=001, NEG_SEL=1, WE=1; PC advances by 4.
- Jump with wrap: PC=0x10, j with offset -2 (0x06FE0000) → next PC=0x0C. Separately, PC=0xFFFFFFFC with a non-branch instruction → next PC=0x00000000.
- Branch on ZERO: beq offset +3 with ZERO=1 → PC+16, WE=0. Same instruction with ZERO=0 → PC+4.
- Stall: IMEM_BUSY=1 for 3 cycles during add → PC, RETIRED unchanged, WE=0 throughout; resumes on release.
- Halt and illegal opcode: opcode 0x2A → HALTED=1, PC frozen, WE=0 for 5 cycles, RETIRED unchanged. RESET → PC=0, HALTED=0.
